// File: rtl/envelope_smoother_pkg.sv
// Shared envelope-block settings offsets, clear bit and gate state encoding.
package envelope_smoother_pkg;

  localparam int SR_ENV_THRESH = 0;
  localparam int SR_ENV_HOLD   = 1;
  localparam int CLEAR_BIT     = 31;

  typedef enum logic [1:0] {
    GATE_CLOSED = 2'd0,
    GATE_OPEN   = 2'd1,
    GATE_HANG   = 2'd2
  } gate_state_t;

  function automatic logic [7:0] sr_addr(input int base, input int ofs);
    return 8'(base + ofs);
  endfunction

endpackage

// File: rtl/envelope_smoother_mag_delay_line.sv
// Ring buffer of the last 2^WIN_LOG2 magnitudes; o_oldest is the sample leaving the window (0 while filling).
// Combinational read, registered write; a clear this cycle makes the pushed sample the first of a fresh window.
module mag_delay_line #(
  parameter int WIN_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [15:0] i_mag,
  output logic [15:0] o_oldest
);

  localparam int N = 1 << WIN_LOG2;

  logic [15:0]         r_buf [N];
  logic [WIN_LOG2-1:0] r_wp;
  logic [WIN_LOG2:0]   r_fill;

  logic [WIN_LOG2-1:0] w_wp;
  logic [WIN_LOG2:0]   w_fill;
  logic                w_full;

  assign w_wp     = i_clear ? '0 : r_wp;
  assign w_fill   = i_clear ? '0 : r_fill;
  assign w_full   = (w_fill == (WIN_LOG2+1)'(N));
  assign o_oldest = w_full ? r_buf[w_wp] : 16'd0;

  // No reset on the storage so it can live in distributed RAM; fill masks stale entries.
  always_ff @(posedge clk) begin
    if (i_push) r_buf[w_wp] <= i_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else if (i_push) begin
      r_wp   <= w_wp + WIN_LOG2'(1);
      r_fill <= w_full ? w_fill : w_fill + (WIN_LOG2+1)'(1);
    end else if (i_clear) begin
      r_wp   <= '0;
      r_fill <= '0;
    end
  end

endmodule

// File: rtl/envelope_smoother.sv
// Boxcar-averages magnitude over 2^WIN_LOG2 samples and gates it with hysteresis/hangover; 1-cycle latency.
// One-deep output register: i_tready = o_tready | ~o_tvalid, outputs held stable under backpressure.
module envelope_smoother
  import envelope_smoother_pkg::*;
#(
  parameter int WIN_LOG2 = 4,
  parameter int SR_BASE  = 130
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tuser,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  localparam int SW = 16 + WIN_LOG2;

  logic [31:0]  r_thresh;
  logic [15:0]  r_hold;
  logic [SW-1:0] r_sum;
  gate_state_t  r_state;
  logic [15:0]  r_hcnt;
  logic [31:0]  r_tdata;
  logic         r_tuser;
  logic         r_tlast;
  logic         r_tvalid;

  logic          w_thr_wr;
  logic          w_hold_wr;
  logic          w_clear;
  logic          w_accept;
  logic [15:0]   w_oldest;
  logic [SW-1:0] w_sum_next;
  logic [15:0]   w_avg;
  gate_state_t   w_state_base;
  gate_state_t   w_state_next;
  logic [15:0]   w_hcnt_base;
  logic [15:0]   w_hcnt_next;

  assign w_thr_wr  = set_stb && (set_addr == sr_addr(SR_BASE, SR_ENV_THRESH));
  assign w_hold_wr = set_stb && (set_addr == sr_addr(SR_BASE, SR_ENV_HOLD));
  assign w_clear   = w_hold_wr && set_data[CLEAR_BIT];
  assign i_tready  = o_tready | ~r_tvalid;
  assign w_accept  = i_tvalid & i_tready;

  mag_delay_line #(.WIN_LOG2(WIN_LOG2)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_push   (w_accept),
    .i_mag    (i_tdata[15:0]),
    .o_oldest (w_oldest)
  );

  // A coincident clear is applied before the sample, so it starts a new window.
  assign w_sum_next   = (w_clear ? '0 : r_sum) + SW'(i_tdata[15:0]) - SW'(w_oldest);
  assign w_avg        = w_sum_next[SW-1:WIN_LOG2];
  assign w_state_base = w_clear ? GATE_CLOSED : r_state;
  assign w_hcnt_base  = w_clear ? 16'd0 : r_hcnt;

  always_comb begin
    w_state_next = w_state_base;
    w_hcnt_next  = w_hcnt_base;
    case (w_state_base)
      GATE_CLOSED: begin
        if (w_avg >= r_thresh[31:16]) w_state_next = GATE_OPEN;
      end
      GATE_OPEN: begin
        if (w_avg < r_thresh[15:0]) begin
          w_hcnt_next  = 16'd0;
          w_state_next = (r_hold == 16'd0) ? GATE_CLOSED : GATE_HANG;
        end
      end
      GATE_HANG: begin
        if (w_avg >= r_thresh[15:0])
          w_state_next = GATE_OPEN;
        else if ({1'b0, w_hcnt_base} + 17'd1 == {1'b0, r_hold})
          w_state_next = GATE_CLOSED;
        else
          w_hcnt_next = w_hcnt_base + 16'd1;
      end
      default: w_state_next = GATE_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= GATE_CLOSED;
      r_hcnt  <= 16'd0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_state <= w_state_next;
      r_hcnt  <= w_hcnt_next;
      r_sum   <= w_sum_next;
    end else if (w_clear) begin
      r_state <= GATE_CLOSED;
      r_hcnt  <= 16'd0;
      r_sum   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_thresh <= 32'hFFFF_FFFF;
      r_hold   <= 16'd0;
    end else begin
      if (w_thr_wr)  r_thresh <= set_data;
      if (w_hold_wr) r_hold   <= set_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tdata  <= {i_tdata[31:16], w_avg};
      r_tuser  <= (w_state_next != GATE_CLOSED);
      r_tlast  <= i_tlast;
    end else if (o_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign o_tdata  = r_tdata;
  assign o_tuser  = r_tuser;
  assign o_tlast  = r_tlast;
  assign o_tvalid = r_tvalid;

endmodule

// File: tb/tb_envelope_smoother.sv
// Bench for envelope_smoother: table vectors plus a scoreboard fed at acceptance and drained at output.
module tb_envelope_smoother;

  localparam int SRB = 130;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tuser;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  logic [31:0] f_i_tdata;
  logic        f_i_tvalid;
  logic        f_i_tready;
  logic [31:0] f_o_tdata;
  logic        f_o_tuser;
  logic        f_o_tlast;
  logic        f_o_tvalid;

  envelope_smoother #(.WIN_LOG2(2), .SR_BASE(SRB)) u_dut (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  envelope_smoother #(.WIN_LOG2(8), .SR_BASE(SRB)) u_full (
    .clk(clk), .reset(reset),
    .set_stb(1'b0), .set_addr(8'd0), .set_data(32'd0),
    .i_tdata(f_i_tdata), .i_tlast(1'b0), .i_tvalid(f_i_tvalid), .i_tready(f_i_tready),
    .o_tdata(f_o_tdata), .o_tuser(f_o_tuser), .o_tlast(f_o_tlast), .o_tvalid(f_o_tvalid),
    .o_tready(1'b1)
  );

  typedef struct {
    logic [15:0] avg;
    logic [15:0] ph;
    logic        tu;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] mag;
    logic [15:0] e_avg;
    logic        e_tu;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int   m_win[$];
  int   m_state, m_hcnt, m_hi, m_lo, m_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_win.delete();
    m_state = 0;
    m_hcnt  = 0;
    m_hi    = 16'hFFFF;
    m_lo    = 16'hFFFF;
    m_hold  = 0;
  endtask

  // Independent reference: window average over a history list and a three-state gate.
  task automatic model_step(input int mag, input bit clr, output int avg, output bit tu);
    int s;
    if (clr) begin
      m_win.delete();
      m_state = 0;
      m_hcnt  = 0;
    end
    m_win.push_back(mag);
    if (m_win.size() > 4) void'(m_win.pop_front());
    s = 0;
    foreach (m_win[i]) s += m_win[i];
    avg = s / 4;
    case (m_state)
      0: if (avg >= m_hi) m_state = 1;
      1: if (avg < m_lo) begin
           m_hcnt  = 0;
           m_state = (m_hold == 0) ? 0 : 2;
         end
      default: begin
        if (avg >= m_lo) m_state = 1;
        else if (m_hcnt + 1 == m_hold) m_state = 0;
        else m_hcnt++;
      end
    endcase
    tu = (m_state != 0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk); #1;
    set_stb = 1'b0;
    if (addr == SRB) begin
      m_hi = data[31:16];
      m_lo = data[15:0];
    end
    if (addr == SRB + 1) begin
      m_hold = data[15:0];
      if (data[31]) begin
        m_win.delete();
        m_state = 0;
        m_hcnt  = 0;
      end
    end
  endtask

  task automatic send(input logic [15:0] mag, input logic [15:0] ph, input bit last, input bit clr,
                      input bit use_tab, input logic [15:0] t_avg, input bit t_tu);
    int   n = 0;
    bit   done = 0;
    int   m_avg;
    bit   m_tu;
    exp_t e;
    i_tdata  = {ph, mag};
    i_tlast  = last;
    i_tvalid = 1'b1;
    if (clr) begin
      set_stb  = 1'b1;
      set_addr = 8'(SRB + 1);
      set_data = {1'b1, 15'd0, 16'(m_hold)};
    end
    while (!done && n < 50) begin
      @(negedge clk);
      if (i_tready) begin
        model_step(mag, clr, m_avg, m_tu);
        e.avg  = use_tab ? t_avg : 16'(m_avg);
        e.tu   = use_tab ? t_tu : m_tu;
        e.ph   = ph;
        e.last = last;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      set_stb = 1'b0;
      n++;
    end
    if (!done) chk("send_timeout", 32'(n), 32'd0);
    i_tvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_tvalid && o_tready && !reset) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", o_tdata, {e.ph, e.avg});
        chk("out_user_last", {30'd0, o_tuser, o_tlast}, {30'd0, e.tu, e.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    vec_t ramp[5];
    vec_t hyst[10];
    logic [15:0] bp_mag[12];
    logic [31:0] hd;
    logic [1:0]  hf;
    int kout;

    ramp = '{'{16'd100, 16'd25, 1'b0}, '{16'd100, 16'd50, 1'b0}, '{16'd100, 16'd75, 1'b0},
             '{16'd100, 16'd100, 1'b0}, '{16'd0, 16'd75, 1'b0}};
    hyst = '{'{16'd100, 16'd25, 1'b0}, '{16'd100, 16'd50, 1'b0}, '{16'd100, 16'd75, 1'b0},
             '{16'd100, 16'd100, 1'b1}, '{16'd0, 16'd75, 1'b1}, '{16'd0, 16'd50, 1'b1},
             '{16'd0, 16'd25, 1'b1}, '{16'd0, 16'd0, 1'b1}, '{16'd0, 16'd0, 1'b0},
             '{16'd0, 16'd0, 1'b0}};
    bp_mag = '{16'd120, 16'd90, 16'd30, 16'd10, 16'd200, 16'd60,
               16'd0, 16'd0, 16'd0, 16'd50, 16'd160, 16'd20};

    reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    f_i_tdata = 32'd0; f_i_tvalid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rst_tdata", o_tdata, 32'd0);
    chk("rst_tuser", {31'd0, o_tuser}, 32'd0);
    chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
    chk("rst_itready", {31'd0, i_tready}, 32'd1);

    // Ramp and decay with reset thresholds
    for (int i = 0; i < 5; i++) begin
      send(ramp[i].mag, 16'hA000 + 16'(i), i == 4, 1'b0, 1'b1, ramp[i].e_avg, ramp[i].e_tu);
      if (i == 0) begin
        chk("lat1_tvalid", {31'd0, o_tvalid}, 32'd1);
        chk("lat1_avg", {16'd0, o_tdata[15:0]}, 32'd25);
      end
    end
    repeat (2) @(posedge clk); #1;

    // Hysteresis and hangover
    wr(8'(SRB), {16'd80, 16'd40});
    wr(8'(SRB + 1), 32'd2);
    wr(8'(SRB + 1), 32'h8000_0002);
    for (int i = 0; i < 10; i++)
      send(hyst[i].mag, 16'hB000 + 16'(i), 1'b0, 1'b0, 1'b1, hyst[i].e_avg, hyst[i].e_tu);
    repeat (2) @(posedge clk); #1;
    chk("hyst_drained", 32'(sb.size()), 32'd0);

    // Backpressure mid-stream
    wr(8'(SRB + 1), 32'h8000_0002);
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(bp_mag[i], 16'hC000 + 16'(i), i == 11, 1'b0, 1'b0, 16'd0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 o_tready = 1'b0;
        @(negedge clk);
        hd = o_tdata;
        hf = {o_tuser, o_tlast};
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("bp_tvalid", {31'd0, o_tvalid}, 32'd1);
          chk("bp_itready", {31'd0, i_tready}, 32'd0);
          chk("bp_tdata_stable", o_tdata, hd);
          chk("bp_flags_stable", {30'd0, o_tuser, o_tlast}, {30'd0, hf});
        end
        @(posedge clk); #1 o_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Clear coincident with a sample
    wr(8'(SRB + 1), 32'h8000_0002);
    for (int i = 0; i < 4; i++)
      send(16'd200, 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(16'd40, 16'hD0FF, 1'b1, 1'b1, 1'b1, 16'd10, 1'b0);

    // Reset while a sample is held and the gate is open
    for (int i = 0; i < 4; i++)
      send(16'd200, 16'hE000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    o_tready = 1'b0;
    chk("rstmid_pre_tvalid", {31'd0, o_tvalid}, 32'd1);
    chk("rstmid_pre_tuser", {31'd0, o_tuser}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_tvalid", {31'd0, o_tvalid}, 32'd0);
    reset = 1'b0;
    chk("rstmid_held_one", 32'(sb.size()), 32'd1);
    sb.delete();
    model_reset();
    o_tready = 1'b1;
    send(16'd100, 16'hE100, 1'b0, 1'b0, 1'b1, 16'd25, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("rstmid_drained", 32'(sb.size()), 32'd0);

    // Full-scale input on the 256-deep window
    kout = 0;
    fork
      begin
        f_i_tdata  = 32'h1234_FFFF;
        f_i_tvalid = 1'b1;
        repeat (300) @(posedge clk);
        #1 f_i_tvalid = 1'b0;
      end
      begin
        repeat (305) begin
          @(negedge clk);
          if (f_o_tvalid) begin
            kout++;
            chk("full_data", f_o_tdata,
                {16'h1234, 16'(((kout > 256 ? 256 : kout) * 65535) >> 8)});
          end
        end
      end
    join
    chk("full_count", 32'(kout), 32'd300);
    chk("full_gate_open", {30'd0, f_o_tuser, f_o_tlast}, {30'd0, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/envelope_smoother.md
# envelope_smoother

Streaming stage that sits directly downstream of the complex-to-magnitude/phase converter in the envelope RFNoC block, between that converter's output and the AXI wrapper's `s_axis_data` input. It takes the 32-bit magnitude/phase sample stream and smooths the magnitude with a boxcar moving average over 2^WIN_LOG2 samples. It then runs a threshold gate with hysteresis and hangover on the smoothed value. It emits the averaged magnitude, the current phase and a per-sample gate flag.

## Interface
- `WIN_LOG2`, default 4: log2 of the averaging window. Legal range is 1..8.
- `SR_BASE`, default 130: settings-bus base address. Registers are at SR_BASE and SR_BASE+1.
- `clk` in 1: compute-engine clock. It is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `set_stb` in 1, `set_addr` in 8, `set_data` in 32: RFNoC settings bus.
- `i_tdata` in 32: input sample. Magnitude (unsigned) is `[15:0]`. Phase is `[31:16]`.
- `i_tlast`, `i_tvalid` in 1; `i_tready` out 1: input AXI-Stream handshake.
- `o_tdata` out 32: output sample. Averaged magnitude is `[15:0]`. Phase passed through is `[31:16]`.
- `o_tuser` out 1: gate flag; 1 means the gate is open.
- `o_tlast`, `o_tvalid` out 1; `o_tready` in 1: output AXI-Stream handshake.

## Operation
- **SR_BASE register:** `{thresh_hi[15:0], thresh_lo[15:0]}`. Reset value is 0xFFFF_FFFF.
- **SR_BASE+1 register:**
  - `[15:0]` is `hold`; reset value 0.
  - Bit 31 written as 1 issues a one-cycle clear. It is self-clearing and not stored.
- **Ring buffer:** N = 2^WIN_LOG2 entries of 16 bits, with write pointer `wp`.
  - On each accepted input, `oldest = (fill < N) ? 0 : buf[wp]`.
  - `buf[wp] <= mag`, `wp <= wp+1` modulo N.
  - `fill` saturates at N.
- **Running sum:** `sum` is 16+WIN_LOG2 bits wide and is unsigned.
  - `sum_next = sum + mag - oldest`. This never underflows or overflows.
  - `avg = sum_next >> WIN_LOG2`, truncated (not rounded).
  - While the window fills, the average ramps up from zero.
- **Gate FSM:** states CLOSED, OPEN, HANG. It is evaluated once per accepted sample, using `avg`.
  - CLOSED → OPEN if `avg >= thresh_hi`.
  - OPEN → HANG if `avg < thresh_lo`, and `hcnt` loads 0. If `hold == 0`, the transition is OPEN → CLOSED directly.
  - HANG → OPEN if `avg >= thresh_lo`.
  - Otherwise in HANG, `hcnt` increments. When `hcnt+1 == hold`, the state goes to CLOSED.
  - `o_tuser` = 1 when the next state is OPEN or HANG.
- **Pass-through fields:** phase and `tlast` pass through unmodified, aligned with their own sample.
- **Clear:**
  - Zeroes `sum`, `fill`, `wp`, and `hcnt`, and sets the FSM to CLOSED.
  - Does not touch the output register or the thresholds.
- **Reset:** clears all of the above. In addition:
  - `o_tvalid`, `o_tdata`, `o_tuser` and `o_tlast` are 0.
  - Thresholds and `hold` return to their reset values.
  - With thresholds at 0xFFFF the gate cannot open unless the average equals 0xFFFF.

## Timing
- Latency is exactly 1 cycle. A sample accepted at edge k appears on `o_*` after edge k.
- **Handshake:**
  - The output register holds the sample.
  - `i_tready = o_tready | ~o_tvalid`, which is combinational and makes a 1-deep pipeline.
  - Sustained throughput is 1 sample/clk while `o_tready` = 1.
  - `o_tdata`, `o_tuser` and `o_tlast` stay stable while `o_tvalid & ~o_tready`.
- When a settings write and a sample acceptance happen in the same cycle, the sample uses the old thresholds and `hold`.
- When a clear and a sample acceptance happen in the same cycle:
  - The clear is applied first.
  - That sample is the first of the new window: `sum_next = mag`, `oldest = 0`, and the FSM is evaluated from CLOSED.
- A clear or a settings write during output backpressure does not alter the held output.
- Reset in mid-stream drops the held output sample (`o_tvalid` goes to 0 in the following cycle).
- `fill` and `wp` wrap: `wp` wraps at N, and `fill` stops at N.

## Structure
- Register offsets go in a shared include, `envelope_regs.vh`, alongside the other envelope-block settings addresses:
  - `SR_ENV_THRESH` = SR_BASE + 0.
  - `SR_ENV_HOLD` = SR_BASE + 1.
  - `CLEAR_BIT` = 31.
- FSM state encodings (CLOSED=0, OPEN=1, HANG=2) are localparams in the same include.
- One sub-module, `mag_delay_line`, holds the N×16 ring buffer together with `wp` and `fill`, and outputs `oldest`. It maps to distributed RAM.
- Sum, FSM, output register and settings decode stay in the top level.

## Test plan
- **Ramp and decay:** WIN_LOG2=2, feed mags 100,100,100,100,0 back-to-back with `o_tready` = 1. Expect averages 25,50,75,100,75, each appearing 1 cycle after acceptance, with the phase echoed.
- **Hysteresis and hangover:** thresh_hi=80, thresh_lo=40, hold=2, window 4, feed mags 100×4,0×6.
  - Expected averages: 25,50,75,100,75,50,25,0,0,0.
  - Expected `o_tuser`: 0,0,0,1,1,1,1,1,0,0. The gate enters HANG on the first sample where avg=25 and closes on the second HANG sample.
- **Backpressure:** hold `o_tready` low for 5 cycles mid-stream. Expect `i_tready` low, `o_*` stable throughout, and no sample lost or duplicated (checked by scoreboard).
- **Clear coincident with a sample:** after a window of 200s, write bit31 in the same cycle as a mag=40 sample. Expect that sample's avg = 10 and `o_tuser` = 0.
- **Full-scale values:** feed mag = 0xFFFF continuously with WIN_LOG2=8. Expect avg to settle at 0xFFFF with no wrap.
- **Reset mid-burst:** assert `reset` while `o_tvalid` = 1 and the gate is OPEN. Expect `o_tvalid` = 0 next cycle, and the first post-reset sample of mag=100 (window 4) to give avg=25 with `o_tuser` = 0.
